// File: rtl/dffnq_scan_seq_if.sv
// dffnq_scan_seq_if: host-side START/ABORT/BUSY/DONE handshake and data words of dffnq_scan_seq.
interface dffnq_scan_seq_if #(parameter int W = 16);
   logic start, abort, busy, done;
   logic [W-1:0] wdata, rdata;
   modport master(output start, abort, wdata, input busy, done, rdata);
   modport slave(input start, abort, wdata, output busy, done, rdata);
endinterface

// File: rtl/dffnq_scan_seq.sv
// dffnq_scan_seq: load/capture sequencer for a negedge dffnq scan chain with a START/BUSY/DONE host handshake.
// Define DFFNQ_SCAN_SEQ_UNLOAD_EN to add an UNLOAD phase so rdata returns the captured chain contents.
module dffnq_scan_seq #(
   parameter int CHAIN_LEN = 16,
   parameter int CAP_CYCLES = 1
) (
   input  logic clkn,
   input  logic rst,
   dffnq_scan_seq_if.slave host,
   input  logic so,
   output logic se,
   output logic si,
   output logic cg_en
);
   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam logic [2:0] IDLE = 3'd0, SHIFT = 3'd1, CAPTURE = 3'd2, FINISH = 3'd3, UNLOAD = 3'd4;
`ifdef DFFNQ_SCAN_SEQ_UNLOAD_EN
   localparam logic [2:0] AFTER_CAP = UNLOAD;
`else
   localparam logic [2:0] AFTER_CAP = FINISH;
`endif
   localparam logic [2:0] AFTER_SHIFT = CAP_CYCLES > 0 ? CAPTURE : AFTER_CAP;
   logic [2:0] state, nxt;
   logic [BW-1:0] bcnt;
   logic [3:0] ccnt;
   logic [CHAIN_LEN-1:0] sreg, sreg_nxt, stage, stage_nxt;
   logic last_bit, last_cap, scanning;
   assign last_bit = bcnt == BW'(CHAIN_LEN - 1);
   assign last_cap = ccnt == 4'(CAP_CYCLES - 1);
   assign scanning = state == SHIFT || state == UNLOAD;
   assign sreg_nxt = state == IDLE ? host.wdata : sreg >> 1;
   // chain bit k appears on so in scan cycle k, so staging fills from the top and ends LSB-aligned
   assign stage_nxt = scanning ? (stage >> 1) | (CHAIN_LEN'(so) << (CHAIN_LEN - 1)) : stage;
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = host.start && !host.abort ? SHIFT : IDLE;
         SHIFT:   nxt = host.abort ? IDLE : last_bit ? AFTER_SHIFT : SHIFT;
         CAPTURE: nxt = host.abort ? IDLE : last_cap ? AFTER_CAP : CAPTURE;
         UNLOAD:  nxt = host.abort ? IDLE : last_bit ? FINISH : UNLOAD;
         default: nxt = IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with the phase they describe
   always_ff @(negedge clkn or posedge rst)
      if (rst) begin
         state <= IDLE;
         bcnt <= '0;
         ccnt <= '0;
         sreg <= '0;
         stage <= '0;
         se <= 1'b0;
         si <= 1'b0;
         cg_en <= 1'b0;
         host.busy <= 1'b0;
         host.done <= 1'b0;
         host.rdata <= '0;
      end else begin
         state <= nxt;
         bcnt <= nxt == state ? bcnt + 1'b1 : '0;
         ccnt <= nxt == state ? ccnt + 1'b1 : '0;
         sreg <= sreg_nxt;
         stage <= stage_nxt;
         se <= nxt == SHIFT || nxt == UNLOAD;
         si <= nxt == SHIFT && sreg_nxt[0];
         cg_en <= nxt == SHIFT || nxt == CAPTURE || nxt == UNLOAD;
         host.busy <= nxt != IDLE;
         host.done <= nxt == FINISH;
         host.rdata <= nxt == FINISH ? stage_nxt : host.rdata;
      end
endmodule

// File: tb/tb_dffnq_scan_seq.sv
// tb_dffnq_scan_seq: randomized self-checking bench; two sequencers (CAP_CYCLES 1 and 0) share stimulus,
// each driving its own behavioural chain whose capture inverts every bit.
module tb_dffnq_scan_seq;
   localparam int CL = 8;
`ifdef DFFNQ_SCAN_SEQ_UNLOAD_EN
   localparam int UL = 1;
`else
   localparam int UL = 0;
`endif
   localparam int LMAX = CL * (1 + UL) + 2;
   logic clkn = 1'b1, rst = 1'b1;
   logic start = 1'b0, abort = 1'b0, load_req = 1'b0;
   logic [CL-1:0] wdata = '0, lv = '0, ch0 = '0, ch1 = '0;
   logic so0, se0, si0, cg0, so1, se1, si1, cg1;
   logic busy_o[2], done_o[2], se_o[2], si_o[2], cg_o[2];
   logic [CL-1:0] rd_o[2], prev_rd[2];
   int n_chk = 0, n_fail = 0;
   dffnq_scan_seq_if #(.W(CL)) h0();
   dffnq_scan_seq_if #(.W(CL)) h1();
   assign h0.start = start;
   assign h1.start = start;
   assign h0.abort = abort;
   assign h1.abort = abort;
   assign h0.wdata = wdata;
   assign h1.wdata = wdata;
   dffnq_scan_seq #(.CHAIN_LEN(CL), .CAP_CYCLES(1)) u0 (.clkn(clkn), .rst(rst), .host(h0), .so(so0), .se(se0), .si(si0), .cg_en(cg0));
   dffnq_scan_seq #(.CHAIN_LEN(CL), .CAP_CYCLES(0)) u1 (.clkn(clkn), .rst(rst), .host(h1), .so(so1), .se(se1), .si(si1), .cg_en(cg1));
   assign busy_o[0] = h0.busy;
   assign busy_o[1] = h1.busy;
   assign done_o[0] = h0.done;
   assign done_o[1] = h1.done;
   assign rd_o[0] = h0.rdata;
   assign rd_o[1] = h1.rdata;
   assign se_o[0] = se0;
   assign se_o[1] = se1;
   assign si_o[0] = si0;
   assign si_o[1] = si1;
   assign cg_o[0] = cg0;
   assign cg_o[1] = cg1;
   assign so0 = ch0[0];
   assign so1 = ch1[0];
   always #5 clkn = ~clkn;
   // chain model: shifts toward bit 0 (the SO end) when scanning, inverts on a capture clock
   always @(negedge clkn)
      if (load_req) begin
         ch0 <= lv;
         ch1 <= lv;
      end else begin
         if (cg0) ch0 <= se0 ? {si0, ch0[CL-1:1]} : ~ch0;
         if (cg1) ch1 <= se1 ? {si1, ch1[CL-1:1]} : ~ch1;
      end

   task automatic test_reset;
      @(posedge clkn);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({busy_o[d], done_o[d], se_o[d], si_o[d], cg_o[d], rd_o[d]} !== '0) begin
            n_fail++;
            $display("FAIL reset d%0d got busy/done/se/si/cg=%b%b%b%b%b rdata=%h want all 0", d, busy_o[d], done_o[d], se_o[d], si_o[d], cg_o[d], rd_o[d]);
         end
         prev_rd[d] = '0;
      end
      rst = 1'b0;
   endtask

   // one full operation from an idle cycle; chain preloaded with p on the START edge
   task automatic test_ops(input logic [CL-1:0] p, input logic [CL-1:0] w);
      int lat, cap;
      logic [3:0] obs, exp;
      logic [CL-1:0] exp_rd;
      load_req = 1'b1;
      lv = p;
      start = 1'b1;
      wdata = w;
      @(posedge clkn);
      load_req = 1'b0;
      start = 1'b0;
      for (int i = 1; i <= LMAX + 1; i++) begin
         for (int d = 0; d < 2; d++) begin
            cap = d == 0 ? 1 : 0;
            lat = CL * (1 + UL) + cap + 1;
            exp_rd = UL != 0 ? (cap % 2 != 0 ? ~w : w) : p;
            exp = i < lat ? (i > CL && i <= CL + cap ? 4'b1001 : 4'b1011) : i == lat ? 4'b1100 : 4'b0000;
            obs = {busy_o[d], done_o[d], se_o[d], cg_o[d]};
            n_chk++;
            if (obs !== exp) begin
               n_fail++;
               $display("FAIL ops d%0d cycle %0d busy/done/se/cg got %b want %b", d, i, obs, exp);
            end
            if (i < lat) begin
               n_chk++;
               if (si_o[d] !== (i <= CL ? w[i-1] : 1'b0)) begin
                  n_fail++;
                  $display("FAIL si d%0d cycle %0d got %b want %b", d, i, si_o[d], i <= CL ? w[i-1] : 1'b0);
               end
            end
            n_chk++;
            if (rd_o[d] !== (i < lat ? prev_rd[d] : exp_rd)) begin
               n_fail++;
               $display("FAIL rdata d%0d cycle %0d got %h want %h", d, i, rd_o[d], i < lat ? prev_rd[d] : exp_rd);
            end
            if (i == lat) prev_rd[d] = exp_rd;
         end
         @(posedge clkn);
      end
   endtask

   task automatic test_abort;
      test_ops(8'h11, UL != 0 ? 8'hEE : 8'h3C);
      n_chk++;
      if (prev_rd[0] !== 8'h11) begin
         n_fail++;
         $display("FAIL abort_prior model rdata %h want 11", prev_rd[0]);
      end
      start = 1'b1;
      wdata = CL'($urandom);
      @(posedge clkn);
      start = 1'b0;
      repeat (2) @(posedge clkn);
      abort = 1'b1;
      @(posedge clkn);
      abort = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({busy_o[d], done_o[d], se_o[d], cg_o[d]} !== 4'b0000 || rd_o[d] !== prev_rd[d]) begin
            n_fail++;
            $display("FAIL abort d%0d got busy/done/se/cg=%b%b%b%b rdata=%h want 0000 rdata=%h", d, busy_o[d], done_o[d], se_o[d], cg_o[d], rd_o[d], prev_rd[d]);
         end
      end
      test_ops(CL'($urandom), CL'($urandom));
   endtask

   task automatic test_start_held;
      int nd[2], lat, lo, hi;
      logic pd[2];
      logic [CL-1:0] w, mch[2], f;
      start = 1'b1;
      abort = 1'b1;
      repeat (3) begin
         @(posedge clkn);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (busy_o[d] !== 1'b0) begin
               n_fail++;
               $display("FAIL start_abort d%0d busy got %b want 0", d, busy_o[d]);
            end
         end
      end
      abort = 1'b0;
      w = CL'($urandom);
      lv = CL'($urandom);
      load_req = 1'b1;
      wdata = w;
      for (int d = 0; d < 2; d++) begin
         nd[d] = 0;
         pd[d] = 1'b0;
         mch[d] = lv;
      end
      for (int c = 0; c < 3 * LMAX + 2 * (LMAX + 2); c++) begin
         @(posedge clkn);
         load_req = 1'b0;
         if (c == 3 * LMAX - 1) start = 1'b0;
         for (int d = 0; d < 2; d++) begin
            f = d == 0 ? ~w : w;
            if (done_o[d]) begin
               nd[d]++;
               n_chk++;
               if (pd[d] !== 1'b0 || rd_o[d] !== (UL != 0 ? f : mch[d])) begin
                  n_fail++;
                  $display("FAIL held d%0d done#%0d prev_done=%b rdata got %h want %h", d, nd[d], pd[d], rd_o[d], UL != 0 ? f : mch[d]);
               end
               prev_rd[d] = UL != 0 ? f : mch[d];
               mch[d] = UL != 0 ? '0 : f;
            end
            pd[d] = done_o[d];
         end
      end
      // restart may take the IDLE cycle after FINISH or land on the edge right after DONE
      for (int d = 0; d < 2; d++) begin
         lat = CL * (1 + UL) + (d == 0 ? 1 : 0) + 1;
         lo = (3 * LMAX - 1) / (lat + 1) + 1;
         hi = (3 * LMAX - 1) / lat + 1;
         n_chk++;
         if (nd[d] < lo || nd[d] > hi) begin
            n_fail++;
            $display("FAIL held_count d%0d got %0d dones want %0d..%0d", d, nd[d], lo, hi);
         end
      end
   endtask

   task automatic test_reset_mid;
      start = 1'b1;
      wdata = CL'($urandom);
      @(posedge clkn);
      start = 1'b0;
      repeat (CL) @(posedge clkn);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({busy_o[d], done_o[d], se_o[d], cg_o[d], rd_o[d]} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid d%0d got busy/done/se/cg=%b%b%b%b rdata=%h want all 0", d, busy_o[d], done_o[d], se_o[d], cg_o[d], rd_o[d]);
         end
         prev_rd[d] = '0;
      end
      #1 rst = 1'b0;
      repeat (3) begin
         @(posedge clkn);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (busy_o[d] !== 1'b0) begin
               n_fail++;
               $display("FAIL post_reset d%0d busy got %b want 0", d, busy_o[d]);
            end
         end
      end
      test_ops(CL'($urandom), CL'($urandom));
   endtask

   initial begin
      test_reset;
      @(posedge clkn);
      test_ops(8'hA5, 8'h3C);
      test_ops(8'h00, 8'hFF);
      for (int k = 0; k < 6; k++) test_ops(CL'($urandom), CL'($urandom));
      test_abort;
      test_start_held;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dffnq_scan_seq.md
Name: dffnq_scan_seq

Overview:
- Scan-chain sequencer for a bank of negative-edge D flops (dffnq family) stitched into a single scan chain of CHAIN_LEN cells.
- Serially loads a word into the chain, applies a programmable number of functional capture clocks, and returns the bits shifted out.
- Sits between a test/config host and the chain's SE/SI/SO pins and its clock-gate enable.
- Single START/BUSY/DONE handshake toward the host.

Parameters:
- CHAIN_LEN, 16, number of flops in the chain; legal range 1..32.
- CAP_CYCLES, 1, number of capture clocks after the load shift; legal range 0..15; 0 skips capture.

Ports:
- CLKN  input  1  clock; all state updates on the falling edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  operation request, sampled only in IDLE.
- ABORT  input  1  cancel the current operation.
- WDATA  input  CHAIN_LEN  load word; captured on the START edge.
- SO  input  1  scan-out of the last chain flop.
- SE  output  1  scan enable to the chain.
- SI  output  1  scan-in to the first chain flop.
- CG_EN  output  1  chain clock-gate enable.
- BUSY  output  1  high in any non-IDLE state.
- DONE  output  1  one-cycle completion pulse.
- RDATA  output  CHAIN_LEN  result word.

Behaviour:
- Reset (async, RST=1):
  - state = IDLE.
  - SE, SI, CG_EN, BUSY, DONE = 0; RDATA = 0.
  - Counters cleared; outputs low immediately, including mid-operation.
  - Operation resumes only after RST deasserts and a new START arrives.
- All outputs are registered and update on the CLKN falling edge.
- States: IDLE, SHIFT, CAPTURE, FINISH.
- IDLE:
  - START=1 and ABORT=0: latch WDATA into the shift register, clear the bit counter, go to SHIFT.
  - The first SHIFT cycle follows on the next edge.
- SHIFT (exactly CHAIN_LEN cycles):
  - SE=1, CG_EN=1, SI = shift register bit 0 (LSB first).
  - Each edge: SO sampled into staging bit k, where k = shift cycle index 0..CHAIN_LEN-1.
  - Each edge: shift register shifts right.
  - After cycle CHAIN_LEN-1: go to CAPTURE if CAP_CYCLES>0, else FINISH.
- CAPTURE (exactly CAP_CYCLES cycles):
  - SE=0, CG_EN=1, SI=0.
  - After the last cycle: go to FINISH.
- FINISH (1 cycle):
  - SE=0, CG_EN=0.
  - Staging register committed to RDATA; DONE=1 for this cycle only.
  - Next state IDLE; BUSY falls together with DONE falling.
- Latency: START edge to DONE = CHAIN_LEN + CAP_CYCLES + 1 cycles; back-to-back START is accepted on the edge after DONE.
- START while BUSY: ignored; no queueing.
- ABORT in SHIFT or CAPTURE:
  - Next edge enters IDLE with SE=CG_EN=0 and no DONE.
  - RDATA keeps its previous value; partial staging is discarded.
- START and ABORT together in IDLE: ABORT wins; no operation starts.
- Counter widths: bit counter is clog2(CHAIN_LEN+1) bits, capture counter 4 bits; neither wraps within a legal operation.
- CG_EN never toggles mid-phase; it is high continuously from the first SHIFT through the last CAPTURE cycle.

Optional Feature:
- Macro: DFFNQ_SCAN_SEQ_UNLOAD_EN.
- Defined:
  - Adds state UNLOAD between CAPTURE and FINISH; it is also entered after SHIFT when CAP_CYCLES=0.
  - UNLOAD runs CHAIN_LEN cycles with SE=1, CG_EN=1, SI=0.
  - SO is re-sampled into staging bit k per cycle, so RDATA holds the captured chain contents.
  - Latency becomes 2*CHAIN_LEN + CAP_CYCLES + 1.
  - ABORT in UNLOAD behaves as in the other busy states.
- Undefined: no UNLOAD state; RDATA holds the bits shifted out during SHIFT, i.e. the pre-load chain contents.

Test Plan:
1. CHAIN_LEN=8, CAP_CYCLES=1, chain model preloaded 8'hA5, START with WDATA=8'h3C:
   - SI sequence 0,0,1,1,1,1,0,0.
   - SE high for exactly 8 cycles, then one cycle with SE=0, CG_EN=1.
   - DONE at cycle 10; RDATA=8'hA5 (unload undefined).
2. Same setup, DFFNQ_SCAN_SEQ_UNLOAD_EN defined, chain capture logic inverts all bits:
   - DONE at cycle 18; RDATA=8'hC3.
3. CAP_CYCLES=0, START with WDATA=8'hFF:
   - No cycle with SE=0 and CG_EN=1.
   - DONE at cycle 9; BUSY high for cycles 1..9.
4. ABORT asserted in SHIFT cycle 3, prior RDATA=8'h11:
   - Next edge: BUSY=0, SE=0, CG_EN=0.
   - No DONE; RDATA stays 8'h11.
   - A new START 1 cycle later is accepted.
5. START held high during BUSY; START and ABORT together in IDLE:
   - Only one DONE per accepted operation.
   - The simultaneous case produces BUSY=0.
6. RST pulsed asynchronously mid-CAPTURE (between edges):
   - SE, CG_EN, BUSY, DONE, RDATA go to 0 without a clock edge.
   - After release, IDLE until the next START.
